ddu_mem_loader: RTL

//  Write-side debug port; the counterpart of the DDU's read-only memory/register inspection path.

---
 rtl/ddu_loader_pkg.sv | 31 +++
 rtl/ddu_byte_packer.sv | 57 +++++
 rtl/ddu_mem_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ddu_loader_pkg.sv
// ============================================================================
//  Module      : ddu_loader_pkg
//  Description : Shared constants for the DDU memory loader: FSM state
//                encoding, error codes and bytes per memory word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddu_loader_pkg;

    // Loader FSM state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_HALT_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] ST_COLLECT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE     = 3'd3;
    localparam logic [STATE_W-1:0] ST_VERIFY    = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERROR     = 3'd6;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_VERIFY  = 2'd2;

    // Bytes packed into one default-width (32-bit) memory word
    localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/ddu_byte_packer.sv
// ============================================================================
//  Module      : ddu_byte_packer
//  Description : Packs accepted bytes little-endian into one memory word.
//                Byte k of a word ends up in bits [8k+7:8k]; word_full
//                flags the cycle in which the last byte of a word arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddu_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_shifted;

    // New bytes enter at the top and move down, so the first byte of a word
    // ends up in the least significant lane after NB shifts.
    generate
        if (NB > 1) begin : g_shift
            assign w_shifted = {byte_in, r_word[DATA_W-1:8]};
        end else begin : g_single
            assign w_shifted = byte_in;
        end
    endgenerate

    assign word_full = accept && (r_idx == C_IDX_LAST);
    assign word      = r_word;

    // Byte index and shift buffer; clear discards any partial word
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (accept) begin
            r_word <= w_shifted;
            r_idx  <= (r_idx == C_IDX_LAST) ? '0 : (r_idx + C_IDX_ONE);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddu_mem_loader.sv
// ============================================================================
//  Module      : ddu_mem_loader
//  Description : Write-side debug port. Halts the CPU through the DDU, packs
//                a byte stream into words and writes them to consecutive
//                memory addresses starting at start_addr.
//  Config      : DDU_LOADER_VERIFY_EN - read back each written word one
//                cycle after the write and flag a mismatch as an error.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddu_mem_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              halt_req,
    input  logic              halt_ack,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_done
);

    import ddu_loader_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   C_TO_LIMIT = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]   C_TO_ONE   = TO_W'(1);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W + 1)'(1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [ADDR_W:0]    r_num;
    logic [ADDR_W:0]    r_words_done;
    logic [1:0]         r_err;
    logic [TO_W-1:0]    r_to_cnt;

    logic               w_accept;
    logic               w_timeout;
    logic               w_last_word;
    logic               w_can_start;
    logic               w_verify_fail;
    logic               w_addr_step;
    logic               w_busy;
    logic               w_drive_mem;
    logic               w_pack_clear;
    logic [DATA_W-1:0]  w_word;
    logic               w_word_full;

    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                         (r_state == ST_ERROR);
    assign w_busy      = (r_state == ST_HALT_WAIT) || (r_state == ST_COLLECT) ||
                         (r_state == ST_WRITE)     || (r_state == ST_VERIFY);
    assign w_timeout   = (r_state == ST_COLLECT) && (r_to_cnt == C_TO_LIMIT);
    // A timeout wins over a byte arriving in the same cycle, so the byte is
    // not acknowledged and the stream keeps it.
    assign byte_ready  = (r_state == ST_COLLECT) && !w_timeout;
    assign w_accept    = byte_valid && byte_ready;
    assign w_last_word = ((r_words_done + C_CNT_ONE) == r_num);

`ifdef DDU_LOADER_VERIFY_EN
    assign w_verify_fail = (r_state == ST_VERIFY) && (mem_rdata != w_word);
    assign w_addr_step   = (r_state == ST_VERIFY) && !w_verify_fail;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;
    assign w_verify_fail  = 1'b0;
    assign w_addr_step    = (r_state == ST_WRITE);
`endif

    // Partial words never survive leaving the write phase of a load
    assign w_pack_clear = !((r_state == ST_COLLECT) || (r_state == ST_WRITE) ||
                            (r_state == ST_VERIFY));

    ddu_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_pack_clear),
        .accept    (w_accept),
        .byte_in   (byte_in),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_next_state = ST_HALT_WAIT;
                end
                ST_HALT_WAIT: begin
                    if (halt_ack) begin
                        w_next_state = (r_num == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_timeout)        w_next_state = ST_ERROR;
                    else if (w_word_full) w_next_state = ST_WRITE;
                end
                ST_WRITE: begin
`ifdef DDU_LOADER_VERIFY_EN
                    w_next_state = ST_VERIFY;
`else
                    w_next_state = w_last_word ? ST_DONE : ST_COLLECT;
`endif
                end
`ifdef DDU_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    // words_done was already bumped when leaving WRITE
                    if (w_verify_fail)              w_next_state = ST_ERROR;
                    else if (r_words_done == r_num) w_next_state = ST_DONE;
                    else                            w_next_state = ST_COLLECT;
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (start) w_next_state = ST_HALT_WAIT;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Load context: address, word count, progress and error code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr   <= '0;
            r_num        <= '0;
            r_words_done <= '0;
            r_err        <= ERR_NONE;
        end else if (abort) begin
            r_words_done <= '0;
            r_err        <= ERR_NONE;
        end else begin
            if (start && w_can_start) begin
                r_cur_addr   <= start_addr;
                r_num        <= num_words;
                r_words_done <= '0;
                r_err        <= ERR_NONE;
            end
            if (r_state == ST_WRITE) begin
                r_words_done <= r_words_done + C_CNT_ONE;
            end
            // Address wraps silently at the top of the memory
            if (w_addr_step) begin
                r_cur_addr <= r_cur_addr + C_ADDR_ONE;
            end
            if (w_timeout) begin
                r_err <= ERR_TIMEOUT;
            end
            if (w_verify_fail) begin
                r_err <= ERR_VERIFY;
            end
        end
    end

    // Idle-cycle counter between accepted bytes, only live in COLLECT
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_COLLECT) || w_accept) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != C_TO_LIMIT) begin
            r_to_cnt <= r_to_cnt + C_TO_ONE;
        end
    end

    assign w_drive_mem = (r_state == ST_WRITE) || (r_state == ST_VERIFY);

    assign halt_req   = w_busy;
    assign busy       = w_busy;
    assign mem_we     = (r_state == ST_WRITE);
    assign mem_addr   = w_drive_mem ? r_cur_addr : '0;
    assign mem_wdata  = w_drive_mem ? w_word : '0;
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign err_code   = r_err;
    assign words_done = r_words_done;

endmodule

`default_nettype wire
